// File: rtl/lu_seq_pkg.sv
// Shared constants for lu_seq: op-code encodings and default widths.
// Optional accumulator feature is controlled by the LU_SEQ_ACC_EN macro.
package lu_seq_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  localparam logic [2:0] OP_NOT_A = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_XNOR  = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_NOR   = 3'b110;
  localparam logic [2:0] OP_INV   = 3'b111;
endpackage

// File: rtl/lu_seq_core.sv
// Combinational bitwise logic unit; the invalid op code yields zero with err set.
module lu_seq_core
  import lu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_NOT_A: result = ~a;
      OP_AND:   result = a & b;
      OP_NAND:  result = ~(a & b);
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      OP_OR:    result = a | b;
      OP_NOR:   result = ~(a | b);
      default:  err    = 1'b1;
    endcase
  end
endmodule

// File: rtl/lu_seq.sv
// Two-stage elastic logic-unit pipeline with op counter.
// Define LU_SEQ_ACC_EN to add the result accumulator selectable via acc_mode.
module lu_seq
  import lu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, b_eff, core_result;
  logic [2:0]       s1_op;
  logic             core_err;
  logic             out_xfer, s2_load, in_xfer;

  assign out_xfer = out_valid && out_ready;
  assign s2_load  = s1_valid && (!out_valid || out_xfer);
  assign in_ready = !s1_valid || s2_load;
  assign in_xfer  = in_valid && in_ready;

`ifdef LU_SEQ_ACC_EN
  logic             s1_acc_mode;
  logic [WIDTH-1:0] acc;

  // acc always holds the last stage-2 result, so chained ops see their predecessor
  assign b_eff = (s1_acc_mode && s1_op != OP_NOT_A) ? acc : s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_acc_mode <= 1'b0;
      acc         <= '0;
    end else begin
      if (in_xfer) s1_acc_mode <= acc_mode;
      if (s2_load) acc <= core_result;
    end
  end
`else
  logic unused_acc_mode;
  assign unused_acc_mode = acc_mode;
  assign b_eff = s1_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  lu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (b_eff),
    .op     (s1_op),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      zero      <= 1'b0;
      op_count  <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        result    <= core_result;
        err       <= core_err;
        zero      <= (core_result == '0);
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_lu_seq.sv
// Randomized + directed bench for lu_seq against a queue-based reference model.
module tb_lu_seq;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, acc_mode, out_valid, out_ready, err, zero;
  logic [W-1:0]  a, b, result;
  logic [2:0]    op;
  logic [CW-1:0] op_count;

  lu_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .zero(zero), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] r; logic e; logic z; } exp_t;
  exp_t         expq[$];
  logic [W-1:0] seen[$];
  logic [W-1:0] macc;
  int           cnt;
  int           n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Results leave in acceptance order, so the accumulator seen by a set is the
  // result of the set accepted just before it.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [2:0] mop, input logic mam);
    exp_t         x;
    logic [W-1:0] bb;
    bb = mb;
`ifdef LU_SEQ_ACC_EN
    if (mam && mop != 3'd0) bb = macc;
`endif
    x.e = 1'b0;
    case (mop)
      3'd0: x.r = ~ma;
      3'd1: x.r = ma & bb;
      3'd2: x.r = ~(ma & bb);
      3'd3: x.r = ma ^ bb;
      3'd4: x.r = ~(ma ^ bb);
      3'd5: x.r = ma | bb;
      3'd6: x.r = ~(ma | bb);
      default: begin x.r = '0; x.e = 1'b1; end
    endcase
    x.z  = (x.r == '0);
    macc = x.r;
    return x;
  endfunction

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid) begin
      if (expq.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else begin
        e = expq[0];
        chk("result", result, e.r);
        chk("err", err, e.e);
        chk("zero", zero, e.z);
        if (out_ready) begin
          void'(expq.pop_front());
          seen.push_back(result);
          cnt++;
        end
      end
    end
    if (in_valid && in_ready) expq.push_back(model(a, b, op, acc_mode));
    @(negedge clk);
    chk("op_count", op_count, cnt % (1 << CW));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_count", op_count, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_zero", zero, 0);
    expq.delete(); seen.delete(); macc = '0; cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] iop, input logic iam);
    in_valid = v; a = ia; b = ib; op = iop; acc_mode = iam;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (expq.size() != 0 || out_valid); i++) tick();
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 1; a = 0; b = 0; op = 0; acc_mode = 0;
    macc = '0; cnt = 0;
    @(negedge clk);
    do_reset();

    // 0x0F & 0xFF with two-edge latency
    drive(1, 8'h0F, 8'hFF, 3'b001, 0); tick();
    in_valid = 0;
    chk("lat_edge1_valid", out_valid, 0);
    tick();
    chk("lat_edge2_valid", out_valid, 1);
    chk("and_result", result, 8'h0F);
    chk("and_err", err, 0);
    chk("and_zero", zero, 0);
    drain();

    // ~0xFF then invalid op
    do_reset();
    drive(1, 8'hFF, 8'h00, 3'b000, 0); tick();
    drive(1, 8'h5A, 8'hA5, 3'b111, 0); tick();
    in_valid = 0; tick();
    chk("nota_zero", seen.size() > 0 ? {31'd0, seen[0] == 8'h00} : 0, 1);
    drain();
    chk("inv_seen", seen.size() == 2 ? seen[1] : 8'hEE, 8'h00);
    chk("op_count_2", op_count, 2);

    // stall with three offered sets
    do_reset();
    out_ready = 0;
    drive(1, 8'h01, 8'h10, 3'b101, 0); tick();
    drive(1, 8'h02, 8'h10, 3'b101, 0); tick();
    drive(1, 8'h04, 8'h10, 3'b101, 0); tick();
    tick();
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_held", result, 8'h11);
    chk("stall_accepted", expq.size(), 2);
    @(negedge clk);
    out_ready = 1;
    for (int i = 0; i < 10 && expq.size() < 3 && in_valid; i++) begin
      tick();
      if (seen.size() + expq.size() >= 3) in_valid = 0;
    end
    drain();
    chk("order_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("order0", seen[0], 8'h11);
      chk("order1", seen[1], 8'h12);
      chk("order2", seen[2], 8'h14);
    end

`ifdef LU_SEQ_ACC_EN
    do_reset();
    drive(1, 8'h01, 8'h00, 3'b011, 1); tick();
    drive(1, 8'h02, 8'h00, 3'b011, 1); tick();
    drive(1, 8'h04, 8'h00, 3'b011, 1); tick();
    drain();
    chk("acc_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("acc0", seen[0], 8'h01);
      chk("acc1", seen[1], 8'h03);
      chk("acc2", seen[2], 8'h07);
    end
`endif

    // reset with both stages full
    do_reset();
    out_ready = 0;
    drive(1, 8'h33, 8'h0F, 3'b001, 0); tick();
    drive(1, 8'h44, 8'h0F, 3'b101, 0); tick();
    tick();
    rst = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    expq.delete(); seen.delete(); macc = '0; cnt = 0;
    in_valid = 0; out_ready = 1;
    @(negedge clk); rst = 1'b0;
    drive(1, 8'hC3, 8'h3C, 3'b011, 0); tick();
    in_valid = 0;
    chk("midrst_lat1", out_valid, 0);
    tick();
    chk("midrst_lat2", out_valid, 1);
    chk("midrst_result", result, 8'hFF);
    drain();

    // counter wrap over 2^CW+3 transfers
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 60 && seen.size() < (1 << CW) + 3; i++) begin
      in_valid = (seen.size() + expq.size()) < (1 << CW) + 3;
      a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 6)); acc_mode = 0;
      tick();
    end
    drain();
    chk("wrap_n", seen.size(), (1 << CW) + 3);
    chk("wrap_end", op_count, 3);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
